// File: rtl/serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : serial_adder_ctrl
// Description : Bit-serial adder controller. Drives a single full-adder cell
//               and a carry flip-flop over a WIDTH-bit operand pair, one bit
//               per clock, LSB first, with a start/busy/done handshake.
//               Optional macro SERIAL_ADDER_SUB_EN adds a 'sub' port that
//               turns the operation into x - y (two's complement).
// Revision    : 1.0 - initial release
// ============================================================================
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int c_CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(WIDTH - 1);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_RUN  = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0]   r_x_sh;
    logic [WIDTH-1:0]   r_y_sh;
    // Only WIDTH-1 result bits need storing: the final bit comes straight
    // from the adder cell on the completion edge.
    logic [WIDTH-2:0]   r_res_sh;
    logic               r_carry;

    logic               w_sub;
    logic               w_accept;
    logic               w_last;
    logic               w_fa_s;
    logic               w_fa_c;
    logic [WIDTH-1:0]   w_res_nxt;

`ifdef SERIAL_ADDER_SUB_EN
    assign w_sub = sub;
`else
    assign w_sub = 1'b0;
`endif

    // Request acceptance, last-bit detect and the shared full-adder cell
    always_comb begin
        w_accept  = start && ((r_state == c_ST_IDLE) || (r_state == c_ST_DONE));
        w_last    = (r_state == c_ST_RUN) && (r_cnt == c_CNT_LAST);
        w_fa_s    = r_x_sh[0] ^ r_y_sh[0] ^ r_carry;
        w_fa_c    = (r_x_sh[0] & r_y_sh[0]) | (r_x_sh[0] & r_carry) | (r_y_sh[0] & r_carry);
        w_res_nxt = {w_fa_s, r_res_sh};
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; start is only honoured in IDLE and DONE
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: if (start) w_state_nxt = c_ST_RUN;
            c_ST_RUN:  if (w_last) w_state_nxt = c_ST_DONE;
            c_ST_DONE: w_state_nxt = start ? c_ST_RUN : c_ST_IDLE;
            default:   w_state_nxt = c_ST_IDLE;
        endcase
    end

    // Handshake outputs decoded from the state register
    always_comb begin
        busy = (r_state == c_ST_RUN);
        done = (r_state == c_ST_DONE);
    end

    // Operand load, bit-serial datapath and result capture
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= '0;
            r_x_sh   <= '0;
            r_y_sh   <= '0;
            r_res_sh <= '0;
            r_carry  <= 1'b0;
            sum      <= '0;
            cout     <= 1'b0;
        end else if (w_accept) begin
            // Subtraction is x + ~y + 1, so the carry seed replaces cin
            r_cnt    <= '0;
            r_x_sh   <= x;
            r_y_sh   <= w_sub ? ~y : y;
            r_res_sh <= '0;
            r_carry  <= w_sub ? 1'b1 : cin;
        end else if (r_state == c_ST_RUN) begin
            r_res_sh <= w_res_nxt[WIDTH-1:1];
            r_carry  <= w_fa_c;
            r_x_sh   <= r_x_sh >> 1;
            r_y_sh   <= r_y_sh >> 1;
            if (w_last) begin
                // sum/cout only move here, so they hold the old result during RUN
                sum  <= w_res_nxt;
                cout <= w_fa_c;
            end else begin
                r_cnt <= r_cnt + c_CNT_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_adder_ctrl
// Description : Scoreboard bench for serial_adder_ctrl (WIDTH=8). Directed
//               operations push hand-derived results; a negedge monitor pops
//               and compares whenever done is presented.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_adder_ctrl;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             cin;
`ifdef SERIAL_ADDER_SUB_EN
    logic             sub;
`endif
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .x     (x),
        .y     (y),
        .cin   (cin),
`ifdef SERIAL_ADDER_SUB_EN
        .sub   (sub),
`endif
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    typedef struct {
        logic [WIDTH:0] res;
        int             due;
    } exp_t;

    exp_t sb[$];
    exp_t r_mon;
    int   cyc     = 0;
    int   acc     = 0;
    int   n_tests = 0;
    int   n_fail  = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Issue one request from IDLE; the accepting edge is the next posedge
    task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic ci,
                         input logic s, input bit expect_it);
        exp_t e;
        x     = a;
        y     = b;
        cin   = ci;
`ifdef SERIAL_ADDER_SUB_EN
        sub   = s;
`endif
        start = 1'b1;
        @(posedge clk); #1;
        acc   = cyc;
        start = 1'b0;
        if (s) e.res = {1'b0, a} + {1'b0, ~b} + 9'd1;
        else   e.res = {1'b0, a} + {1'b0, b} + {8'd0, ci};
        e.due = acc + WIDTH;
        if (expect_it) sb.push_back(e);
    endtask

    // Monitor: every done pulse must match the oldest expected result and due cycle
    always @(negedge clk) begin
        if (done) begin
            if (sb.size() == 0) begin
                check("no_extra_done", {63'd0, done}, 64'd0);
            end else begin
                r_mon = sb.pop_front();
                check("sum",     {56'd0, sum}, {56'd0, r_mon.res[7:0]});
                check("cout",    {63'd0, cout}, {63'd0, r_mon.res[8]});
                check("latency", 64'(cyc), 64'(r_mon.due));
            end
        end else if (sb.size() > 0 && cyc > sb[0].due) begin
            check("done_timeout", {63'd0, done}, 64'd1);
            r_mon = sb.pop_front();
        end
    end

    initial begin
        exp_t e;
        rst   = 1'b1;
        start = 1'b0;
        x     = '0;
        y     = '0;
        cin   = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
        sub   = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_sum",  {56'd0, sum},  64'd0);
        check("rst_cout", {63'd0, cout}, 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Zero operands: busy for exactly 8 cycles, then done
        issue(8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
        check("busy_run", {63'd0, busy}, 64'd1);
        for (int i = 0; i < 7; i++) begin
            @(posedge clk); #1;
            check("busy_run", {63'd0, busy}, 64'd1);
        end
        @(posedge clk); #1;
        check("busy_end", {63'd0, busy}, 64'd0);
        check("done_end", {63'd0, done}, 64'd1);
        repeat (2) @(posedge clk); #1;

        // Carry ripple through every bit
        issue(8'hFF, 8'h01, 1'b0, 1'b0, 1'b1);
        repeat (10) @(posedge clk); #1;
        issue(8'hA5, 8'h5A, 1'b1, 1'b0, 1'b1);
        repeat (10) @(posedge clk); #1;

        // Back-to-back with start held high; second operands shown in DONE
        x = 8'h12; y = 8'h34; cin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        acc = cyc;
        e.res = 9'h046; e.due = acc + WIDTH; sb.push_back(e);
        repeat (8) @(posedge clk); #1;
        check("b2b_done", {63'd0, done}, 64'd1);
        x = 8'h80; y = 8'h80;
        @(posedge clk); #1;
        check("b2b_no_idle", {63'd0, busy}, 64'd1);
        check("b2b_accept_cycle", 64'(cyc), 64'(acc + WIDTH + 1));
        acc = cyc;
        e.res = 9'h100; e.due = acc + WIDTH; sb.push_back(e);
        start = 1'b0;
        repeat (10) @(posedge clk); #1;

        // Start pulsed during RUN must be ignored; result holds meanwhile
        issue(8'h10, 8'h20, 1'b0, 1'b0, 1'b1);
        repeat (3) @(posedge clk); #1;
        x = 8'h01; y = 8'h01; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("hold_sum_ign",  {56'd0, sum},  64'h00);
        check("hold_cout_ign", {63'd0, cout}, 64'd1);
        repeat (8) @(posedge clk); #1;

        // Mid-run reset discards the partial result
        issue(8'hF0, 8'h0F, 1'b0, 1'b0, 1'b0);
        repeat (3) @(posedge clk); #1;
        check("hold_sum_run",  {56'd0, sum},  64'h30);
        check("hold_cout_run", {63'd0, cout}, 64'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_busy", {63'd0, busy}, 64'd0);
        check("abort_done", {63'd0, done}, 64'd0);
        check("abort_sum",  {56'd0, sum},  64'd0);
        check("abort_cout", {63'd0, cout}, 64'd0);
        repeat (12) @(posedge clk); #1;

        // Reset and start together: request dropped
        rst = 1'b1; start = 1'b1; x = 8'h01; y = 8'h01;
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0;
        check("rst_start_busy", {63'd0, busy}, 64'd0);
        repeat (12) @(posedge clk); #1;

`ifdef SERIAL_ADDER_SUB_EN
        // Subtract; cin is ignored when sub=1
        issue(8'h10, 8'h01, 1'b0, 1'b1, 1'b1);
        repeat (10) @(posedge clk); #1;
        issue(8'h01, 8'h02, 1'b1, 1'b1, 1'b1);
        repeat (10) @(posedge clk); #1;
        sub = 1'b0;
`endif

        repeat (4) @(posedge clk); #1;
        check("queue_drained", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/serial_adder_ctrl.md
# serial_adder_ctrl

- Bit-serial adder controller.
- Sequences one full-adder cell plus a carry flip-flop over a WIDTH-bit operand pair, one bit per clock, LSB first.
- Handshake: start/busy/done.
- Sits between a requesting datapath and the shared one-bit full-adder cell, giving multi-bit addition at minimum area.

## Interface
Parameters:
- WIDTH, 8, operand and result width in bits; legal range 2..64.

Ports:
- clk  input  1  rising-edge clock; one clock domain only.
- rst  input  1  synchronous, active-high reset; dominates all other inputs.
- start  input  1  request; sampled only in IDLE or DONE.
- x  input  WIDTH  operand A; sampled on the accepting edge.
- y  input  WIDTH  operand B; sampled on the accepting edge.
- cin  input  1  carry-in; sampled on the accepting edge.
- sub  input  1  subtract select; present only with SERIAL_ADDER_SUB_EN.
- busy  output  1  high while bits are being processed.
- done  output  1  one-cycle completion pulse.
- sum  output  WIDTH  registered result.
- cout  output  1  registered final carry-out.

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 loads x, y and cin into internal shift registers and the carry flip-flop.
  - Clears the bit counter; next state RUN.
  - start=0: remain in IDLE.
- RUN, on each edge:
  - The full-adder cell sees x_sh[0], y_sh[0] and carry.
  - Its sum bit shifts into the MSB of the result shift register.
  - Its carry-out loads the carry flip-flop.
  - x_sh and y_sh shift right by one.
  - Counter increments.
- RUN exit:
  - On the edge where counter == WIDTH-1, sum and cout load from the completed result and carry.
  - Next state DONE.
- DONE:
  - Lasts exactly one cycle.
  - start=1 is accepted exactly as in IDLE (back-to-back operation), next state RUN.
  - Otherwise next state IDLE.
- start in RUN is ignored; operands are not re-sampled.
- Arithmetic: {cout, sum} = x + y + cin, modulo 2^(WIDTH+1); no truncation beyond cout.
- Hold rule: sum and cout change only on a completion edge or on reset. During RUN they hold the previous result.
- Counter width: $clog2(WIDTH); no wrap beyond WIDTH-1.

## Timing
- Reset value of every output:
  - busy=0, done=0, sum=0, cout=0.
  - State IDLE; counter, shift registers and carry all cleared.
- Accepting edge k (start=1 in IDLE/DONE):
  - busy=1 from after edge k.
  - Bits processed on edges k+1 .. k+WIDTH.
- Completion:
  - At edge k+WIDTH, busy falls, done rises, and sum/cout update.
  - done falls after edge k+WIDTH+1 unless a new operation completes there; for WIDTH ≥ 2 it cannot.
- Latency: WIDTH cycles from the accepting edge to done.
- Throughput: one operation per WIDTH+1 cycles with start held high.
- Reset mid-operation:
  - rst=1 on any edge aborts.
  - All outputs return to reset values on that edge; the partial result is discarded.
  - rst and start high together: reset wins and the request is dropped.

## Configuration
- Macro: SERIAL_ADDER_SUB_EN.
- Defined:
  - Port sub exists and is sampled with the operands.
  - sub=1 loads ~y into y_sh and forces the carry flip-flop to 1; cin is ignored.
  - Result is x − y; cout=1 means no borrow (x ≥ y unsigned).
  - sub=0 behaves as plain add.
- Undefined:
  - No sub port; add-only.
  - Logic identical to the defined build with sub tied 0.

## Test plan
All scenarios use WIDTH=8.
- Reset check: assert rst, release, then start with x=0x00, y=0x00, cin=0 -> done exactly 8 cycles after the accepting edge, sum=0x00, cout=0, busy high for 8 cycles.
- Carry ripple: x=0xFF, y=0x01, cin=0 -> sum=0x00, cout=1. Then x=0xA5, y=0x5A, cin=1 -> sum=0x00, cout=1.
- Back-to-back: hold start=1 with x=0x12, y=0x34, then x=0x80, y=0x80 presented on the DONE cycle -> first done with 0x46/0; the second operation is accepted in DONE, done 8 cycles later with 0x00/1, no IDLE cycle between.
- Ignored start: pulse start with x=0x01, y=0x01 during RUN of 0x10+0x20 -> result 0x30/0, no extra done pulse; sum holds the old value during RUN.
- Mid-run reset: assert rst at cycle 4 of an operation on 0xF0+0x0F -> next cycle busy=0, done=0, sum=0x00, cout=0, no done pulse follows. Also start and rst together -> no operation.
- Subtract, with SERIAL_ADDER_SUB_EN:
  - sub=1, x=0x10, y=0x01 -> sum=0x0F, cout=1.
  - x=0x01, y=0x02 -> sum=0xFF, cout=0.
